// File: rtl/fir_tap_ctrl.sv
// fir_tap_ctrl: sequences delay-line load, MAC tap stepping, pipeline drain and output handshake for the float FIR.
// Optional build macro FIR_CTRL_OVERLAP_EN lets a new sample be accepted on the same edge the result is taken.
module fir_tap_ctrl #(
    parameter int NTAPS   = 4,
    parameter int TAP_W   = 2,
    parameter int MAC_LAT = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             LdD,
    output logic [TAP_W-1:0] tap_sel,
    output logic             acc_clr,
    output logic             acc_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int CW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(NTAPS - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);

    typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_t;

    state_t           state_q, state_d;
    logic [TAP_W-1:0] tap_sel_q, tap_sel_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // state, tap index and drain counter; clr low drops any in-flight result
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= IDLE;
            tap_sel_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            tap_sel_q <= tap_sel_d;
            cnt_q     <= cnt_d;
        end
    end

    // next state: tap index and drain count only advance in their own states, else rest at 0
    always_comb begin
        state_d   = state_q;
        tap_sel_d = '0;
        cnt_d     = '0;
        case (state_q)
            IDLE:  state_d = LdD ? MAC : IDLE;
            MAC: begin
                tap_sel_d = (tap_sel_q == TAP_LAST) ? '0 : tap_sel_q + TAP_W'(1);
                state_d   = (tap_sel_q != TAP_LAST) ? MAC : (MAC_LAT > 0) ? DRAIN : OUT;
            end
            DRAIN: begin
                cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
                state_d = (cnt_q == CNT_LAST) ? OUT : DRAIN;
            end
            OUT:   state_d = !out_ready ? OUT : LdD ? MAC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // outputs decoded from state; the load strobe is gated by clr so reset never shifts the delay line
    always_comb begin
`ifdef FIR_CTRL_OVERLAP_EN
        in_ready  = (state_q == IDLE) || (state_q == OUT && out_ready);
`else
        in_ready  = (state_q == IDLE);
`endif
        LdD       = in_valid && in_ready && clr;
        acc_en    = (state_q == MAC);
        acc_clr   = (state_q == MAC) && (tap_sel_q == '0);
        out_valid = (state_q == OUT);
        busy      = (state_q != IDLE);
        tap_sel   = tap_sel_q;
    end

endmodule
